// File: rtl/raw_window_3x6_gen_if.sv
`default_nettype none
// ============================================================================
// Module      : raw_window_3x6_gen_if
// Description : Beat-stream bundle between the line-buffer chain and the
//               3x6 RAW window generator. The master drives the three
//               beat-aligned row streams; the slave returns the windows.
// Revision    : 1.0 - initial release
// ============================================================================
interface raw_window_3x6_gen_if;
  logic        I_tuser;
  logic        I_valid;
  logic [1:0]  I_row_mask;
  logic [32:0] I_row0;
  logic [32:0] I_row1;
  logic [32:0] I_row2;
  logic        O_valid;
  logic        O_tuser;
  logic        O_tlast;
  logic        O_frame_done;
  logic [47:0] O_win_r0;
  logic [47:0] O_win_r1;
  logic [47:0] O_win_r2;

  modport master (
    output I_tuser, I_valid, I_row_mask, I_row0, I_row1, I_row2,
    input  O_valid, O_tuser, O_tlast, O_frame_done, O_win_r0, O_win_r1, O_win_r2
  );

  modport slave (
    input  I_tuser, I_valid, I_row_mask, I_row0, I_row1, I_row2,
    output O_valid, O_tuser, O_tlast, O_frame_done, O_win_r0, O_win_r1, O_win_r2
  );
endinterface
`default_nettype wire

// File: rtl/raw_window_3x6_gen.sv
`default_nettype none
// ============================================================================
// Module      : raw_window_3x6_gen
// Description : Builds a 3-row x 6-pixel window per 4-pixel beat from the
//               live row and two delayed rows. Neighbours come from adjacent
//               beats; line edges are border-filled. Window for beat k-1 is
//               registered out the cycle after beat k is accepted; the final
//               beat of a line is emitted from the FLUSH state.
//               Macro RAW_WIN_BORDER_MIRROR_EN: Bayer-safe mirror fill
//               (left=p1, right=p2); undefined: edge replicate (p0 / p3).
// Revision    : 1.0 - initial release
// ============================================================================
module raw_window_3x6_gen #(
  parameter int IMG_WIDTH  = 1920,
  parameter int IMG_HEIGHT = 1080
) (
  input  logic                I_clk,
  input  logic                I_rst,
  raw_window_3x6_gen_if.slave bus
);

  localparam int W4     = IMG_WIDTH >> 2;
  localparam int COL_W  = (W4 > 1) ? $clog2(W4) : 1;
  localparam int LINE_W = $clog2(IMG_HEIGHT + 1);

  localparam logic [COL_W-1:0]  c_last_col  = COL_W'(W4 - 1);
  localparam logic [LINE_W-1:0] c_last_line = LINE_W'(IMG_HEIGHT - 1);
  localparam logic [LINE_W-1:0] c_line_sat  = LINE_W'(IMG_HEIGHT);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FIRST = 2'd1,
    ST_RUN   = 2'd2,
    ST_FLUSH = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [COL_W-1:0]   col_q, col_d;
  logic [LINE_W-1:0]  line_q, line_d;
  logic [31:0]        cur_q [3];
  logic [31:0]        cur_d [3];
  logic [7:0]         prev_q [3];
  logic [7:0]         prev_d [3];
  logic               left_edge_q, left_edge_d;
  logic [1:0]         mask_q, mask_d;
  logic               sof_q, sof_d;
  logic               valid_q, valid_d;
  logic               tuser_q, tuser_d;
  logic               tlast_q, tlast_d;
  logic               done_q, done_d;
  logic [47:0]        win_q [3];
  logic [47:0]        win_d [3];

  // Per-cycle decode helpers
  state_t             w_eff_state;
  logic [COL_W-1:0]   w_eff_col;
  logic [COL_W-1:0]   w_beat_col;
  logic               w_emit;
  logic               w_last;
  logic               w_load;
  logic               w_line_start;
  logic [31:0]        w_new_beat [3];
  logic               w_unused_bits;

  assign w_new_beat[0] = bus.I_row0[31:0];
  assign w_new_beat[1] = bus.I_row1[31:0];
  assign w_new_beat[2] = bus.I_row2[31:0];
  assign w_unused_bits = ^{bus.I_row0[32], bus.I_row1[32], bus.I_row2[32]};

  // Left neighbour substituted at the start of a line
  function automatic logic [7:0] left_fill(input logic [31:0] beat);
`ifdef RAW_WIN_BORDER_MIRROR_EN
    return beat[15:8];
`else
    return beat[7:0];
`endif
  endfunction

  // Right neighbour substituted at the end of a line
  function automatic logic [7:0] right_fill(input logic [31:0] beat);
`ifdef RAW_WIN_BORDER_MIRROR_EN
    return beat[23:16];
`else
    return beat[31:24];
`endif
  endfunction

  // Next-state, window assembly and counter update
  always_comb begin
    state_d     = state_q;
    col_d       = col_q;
    line_d      = line_q;
    mask_d      = mask_q;
    left_edge_d = left_edge_q;
    sof_d       = sof_q;
    valid_d     = 1'b0;
    tuser_d     = 1'b0;
    tlast_d     = 1'b0;
    done_d      = 1'b0;
    for (int r = 0; r < 3; r++) begin
      cur_d[r]  = cur_q[r];
      prev_d[r] = prev_q[r];
      win_d[r]  = '0;
    end
    w_emit       = 1'b0;
    w_last       = 1'b0;
    w_load       = 1'b0;
    w_line_start = 1'b0;
    w_beat_col   = '0;
    w_eff_state  = state_q;
    w_eff_col    = col_q;

    // Start of frame clears position and kills any pending emission;
    // a beat presented alongside it is the first beat of the frame.
    if (bus.I_tuser) begin
      w_eff_state = ST_FIRST;
      w_eff_col   = '0;
      line_d      = '0;
      sof_d       = 1'b1;
    end
    state_d = w_eff_state;
    col_d   = w_eff_col;

    case (w_eff_state)
      ST_IDLE:  ;
      ST_FIRST: begin
        w_load       = bus.I_valid;
        w_line_start = 1'b1;
      end
      ST_RUN: begin
        w_load = bus.I_valid;
        w_emit = bus.I_valid;
      end
      ST_FLUSH: begin
        w_emit       = 1'b1;
        w_last       = 1'b1;
        w_load       = bus.I_valid;
        w_line_start = 1'b1;
      end
      default: ;
    endcase

    // Row1 absent means no usable window; row2 absent mirrors row0 about row1
    if (w_emit && mask_q[0]) begin
      for (int r = 0; r < 3; r++) begin
        win_d[r] = {(w_last      ? right_fill(cur_q[r]) : w_new_beat[r][7:0]),
                    cur_q[r],
                    (left_edge_q ? left_fill(cur_q[r])  : prev_q[r])};
      end
      if (!mask_q[1]) begin
        win_d[2] = win_d[0];
      end
      valid_d = 1'b1;
      tuser_d = sof_q;
      tlast_d = w_last;
      sof_d   = 1'b0;
    end

    if (w_last) begin
      line_d  = (line_q == c_line_sat) ? line_q : line_q + LINE_W'(1);
      done_d  = (line_q == c_last_line);
      state_d = ST_FIRST;
      col_d   = '0;
    end

    if (w_load) begin
      for (int r = 0; r < 3; r++) begin
        prev_d[r] = cur_q[r][31:24];
        cur_d[r]  = w_new_beat[r];
      end
      mask_d      = bus.I_row_mask;
      left_edge_d = w_line_start;
      w_beat_col  = w_line_start ? '0 : w_eff_col;
      if (w_beat_col == c_last_col) begin
        state_d = ST_FLUSH;
        col_d   = '0;
      end else begin
        state_d = ST_RUN;
        col_d   = w_beat_col + COL_W'(1);
      end
    end
  end

  // State, row history and registered outputs
  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      state_q     <= ST_IDLE;
      col_q       <= '0;
      line_q      <= '0;
      mask_q      <= '0;
      left_edge_q <= 1'b0;
      sof_q       <= 1'b0;
      valid_q     <= 1'b0;
      tuser_q     <= 1'b0;
      tlast_q     <= 1'b0;
      done_q      <= 1'b0;
      for (int r = 0; r < 3; r++) begin
        cur_q[r]  <= '0;
        prev_q[r] <= '0;
        win_q[r]  <= '0;
      end
    end else begin
      state_q     <= state_d;
      col_q       <= col_d;
      line_q      <= line_d;
      mask_q      <= mask_d;
      left_edge_q <= left_edge_d;
      sof_q       <= sof_d;
      valid_q     <= valid_d;
      tuser_q     <= tuser_d;
      tlast_q     <= tlast_d;
      done_q      <= done_d;
      for (int r = 0; r < 3; r++) begin
        cur_q[r]  <= cur_d[r];
        prev_q[r] <= prev_d[r];
        win_q[r]  <= win_d[r];
      end
    end
  end

  assign bus.O_valid      = valid_q;
  assign bus.O_tuser      = tuser_q;
  assign bus.O_tlast      = tlast_q;
  assign bus.O_frame_done = done_q;
  assign bus.O_win_r0     = win_q[0];
  assign bus.O_win_r1     = win_q[1];
  assign bus.O_win_r2     = win_q[2];

endmodule
`default_nettype wire

// File: tb/tb_raw_window_3x6_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_raw_window_3x6_gen
// Description : Scoreboard bench for raw_window_3x6_gen (16-pixel lines,
//               2-line frames). Stimulus pushes expected windows into a
//               queue; a negedge monitor pops and compares every O_valid.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_raw_window_3x6_gen;

  localparam int IMG_WIDTH  = 16;
  localparam int IMG_HEIGHT = 2;
  localparam int W4         = IMG_WIDTH >> 2;

  logic clk;
  logic rst;

  raw_window_3x6_gen_if bus ();

  raw_window_3x6_gen #(
    .IMG_WIDTH  (IMG_WIDTH),
    .IMG_HEIGHT (IMG_HEIGHT)
  ) dut (
    .I_clk (clk),
    .I_rst (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        tuser;
    logic        tlast;
    logic        done;
    logic [47:0] r0;
    logic [47:0] r1;
    logic [47:0] r2;
  } exp_t;

  exp_t exp_q[$];
  int   total     = 0;
  int   bad       = 0;
  int   done_seen = 0;
  int   exp_done  = 0;
  int   exp_line  = 0;
  bit   exp_sof   = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic logic [31:0] beat_word(input logic [7:0] base, input int k);
    logic [31:0] w;
    for (int j = 0; j < 4; j++) w[8*j +: 8] = base + 8'(4*k + j);
    return w;
  endfunction

  // Reference window row: pixel i of the line is base+i
  function automatic logic [47:0] win_row(input logic [7:0] base, input int k);
    logic [7:0] l;
    logic [7:0] r;
    if (k == 0) begin
`ifdef RAW_WIN_BORDER_MIRROR_EN
      l = base + 8'd1;
`else
      l = base;
`endif
    end else begin
      l = base + 8'(4*k - 1);
    end
    if (k == W4 - 1) begin
`ifdef RAW_WIN_BORDER_MIRROR_EN
      r = base + 8'(4*k + 2);
`else
      r = base + 8'(4*k + 3);
`endif
    end else begin
      r = base + 8'(4*k + 4);
    end
    return {r, beat_word(base, k), l};
  endfunction

  task automatic start_frame();
    exp_sof  = 1'b1;
    exp_line = 0;
  endtask

  task automatic push_line(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                           input logic [1:0] mask, input int nwin);
    exp_t e;
    for (int k = 0; k < nwin; k++) begin
      if (mask[0]) begin
        e.r0    = win_row(b0, k);
        e.r1    = win_row(b1, k);
        e.r2    = mask[1] ? win_row(b2, k) : e.r0;
        e.tuser = exp_sof;
        e.tlast = (k == W4 - 1);
        e.done  = (k == W4 - 1) && (exp_line == IMG_HEIGHT - 1);
        exp_sof = 1'b0;
        exp_q.push_back(e);
      end
    end
    if (nwin == W4) begin
      if (exp_line == IMG_HEIGHT - 1) exp_done++;
      if (exp_line < IMG_HEIGHT) exp_line++;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_beats(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                            input logic [1:0] mask, input int first_k, input int nbeats,
                            input bit gap, input bit tu_first);
    for (int k = first_k; k < first_k + nbeats; k++) begin
      bus.I_valid    = 1'b1;
      bus.I_tuser    = tu_first && (k == first_k);
      bus.I_row_mask = mask;
      bus.I_row0     = {1'b1, beat_word(b0, k)};
      bus.I_row1     = {1'b1, beat_word(b1, k)};
      bus.I_row2     = {1'b1, beat_word(b2, k)};
      @(posedge clk);
      #1;
      bus.I_valid = 1'b0;
      bus.I_tuser = 1'b0;
      bus.I_row0  = 33'h0_DEAD_BEEF;
      bus.I_row1  = 33'h1_CAFE_F00D;
      bus.I_row2  = 33'h0_5A5A_A5A5;
      if (gap) idle(1);
    end
  endtask

  // Monitor: every presented window must match the head of the scoreboard
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (bus.O_frame_done) done_seen++;
      if (bus.O_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_window", 64'(bus.O_valid), 64'd0);
        end else begin
          e = exp_q.pop_front();
          chk("win_r0", 64'(bus.O_win_r0), 64'(e.r0));
          chk("win_r1", 64'(bus.O_win_r1), 64'(e.r1));
          chk("win_r2", 64'(bus.O_win_r2), 64'(e.r2));
          chk("tuser_tlast_done", 64'({bus.O_tuser, bus.O_tlast, bus.O_frame_done}),
              64'({e.tuser, e.tlast, e.done}));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    bad++;
    total++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    rst            = 1'b1;
    bus.I_tuser    = 1'b0;
    bus.I_valid    = 1'b0;
    bus.I_row_mask = 2'b11;
    bus.I_row0     = '0;
    bus.I_row1     = '0;
    bus.I_row2     = '0;
    idle(3);
    chk("reset_valid", 64'(bus.O_valid), 64'd0);
    chk("reset_flags", 64'({bus.O_tuser, bus.O_tlast, bus.O_frame_done}), 64'd0);
    chk("reset_win_r0", 64'(bus.O_win_r0), 64'd0);
    chk("reset_win_r2", 64'(bus.O_win_r2), 64'd0);
    rst = 1'b0;

    // IDLE ignores beats until a start of frame
    send_beats(8'h11, 8'h22, 8'h33, 2'b11, 0, 2, 1'b0, 1'b0);
    idle(2);

    // Frame A: row1 ramp 0x00..0x0F continuous, then 1010 valid line
    start_frame();
    push_line(8'h40, 8'h00, 8'h80, 2'b11, W4);
    send_beats(8'h40, 8'h00, 8'h80, 2'b11, 0, W4, 1'b0, 1'b1);
    idle(2);
    push_line(8'h50, 8'h10, 8'h90, 2'b11, W4);
    send_beats(8'h50, 8'h10, 8'h90, 2'b11, 0, W4, 1'b1, 1'b0);
    idle(3);

    // Frame B: next line beat0 arrives in the FLUSH cycle, line saturates
    start_frame();
    push_line(8'h60, 8'h20, 8'hA0, 2'b11, W4);
    send_beats(8'h60, 8'h20, 8'hA0, 2'b11, 0, W4, 1'b0, 1'b1);
    push_line(8'h70, 8'h30, 8'hB0, 2'b11, W4);
    send_beats(8'h70, 8'h30, 8'hB0, 2'b11, 0, W4, 1'b0, 1'b0);
    push_line(8'h68, 8'h28, 8'hA8, 2'b11, W4);
    send_beats(8'h68, 8'h28, 8'hA8, 2'b11, 0, W4, 1'b0, 1'b0);
    idle(2);

    // Vertical masks: row2 mirrored, then no windows at all
    push_line(8'h44, 8'h24, 8'hC4, 2'b01, W4);
    send_beats(8'h44, 8'h24, 8'hC4, 2'b01, 0, W4, 1'b0, 1'b0);
    idle(2);
    push_line(8'h46, 8'h26, 8'hC6, 2'b00, W4);
    send_beats(8'h46, 8'h26, 8'hC6, 2'b00, 0, W4, 1'b0, 1'b0);
    idle(3);

    // Reset mid-line: outputs clear next clock, next frame flags tuser
    start_frame();
    push_line(8'h48, 8'h0C, 8'h88, 2'b11, 2);
    send_beats(8'h48, 8'h0C, 8'h88, 2'b11, 0, 3, 1'b0, 1'b1);
    rst = 1'b1;
    idle(1);
    chk("midline_rst_valid", 64'(bus.O_valid), 64'd0);
    chk("midline_rst_win_r1", 64'(bus.O_win_r1), 64'd0);
    rst     = 1'b0;
    exp_sof = 1'b0;
    idle(1);
    start_frame();
    push_line(8'h52, 8'h12, 8'h92, 2'b11, W4);
    send_beats(8'h52, 8'h12, 8'h92, 2'b11, 0, W4, 1'b0, 1'b1);
    idle(2);

    // Start of frame mid-line with the new frame's first beat
    start_frame();
    push_line(8'h54, 8'h14, 8'h94, 2'b11, 2);
    send_beats(8'h54, 8'h14, 8'h94, 2'b11, 0, 3, 1'b0, 1'b1);
    start_frame();
    push_line(8'h58, 8'h18, 8'h98, 2'b11, W4);
    send_beats(8'h58, 8'h18, 8'h98, 2'b11, 0, 1, 1'b0, 1'b1);
    chk("midline_tuser_valid", 64'(bus.O_valid), 64'd0);
    chk("midline_tuser_win_r0", 64'(bus.O_win_r0), 64'd0);
    send_beats(8'h58, 8'h18, 8'h98, 2'b11, 1, W4 - 1, 1'b0, 1'b0);
    idle(5);

    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    chk("frame_done_count", 64'(done_seen), 64'(exp_done));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
